// File: rtl/cas_pkg.sv
// cas_pkg: shared state encoding, default datapath width and pass-counter width helper.
// Rev 1.0
`default_nettype none

package cas_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CAS_BITS = 4;

  function automatic int pass_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cas3.sv
// cas3: combinational three-input compare-and-swap, outputs ordered a_new >= b_new >= c_new.
// Rev 1.0
`default_nettype none

module cas3 #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [BITS-1:0] c,
  output logic [BITS-1:0] a_new,
  output logic [BITS-1:0] b_new,
  output logic [BITS-1:0] c_new
);

  logic [BITS-1:0] hi_ab;
  logic [BITS-1:0] lo_ab;
  logic [BITS-1:0] hi_lc;

  // Three-comparator network: order (a,b), push the smaller against c, then settle the top two.
  assign hi_ab = (a >= b) ? a : b;
  assign lo_ab = (a >= b) ? b : a;
  assign hi_lc = (lo_ab >= c) ? lo_ab : c;
  assign c_new = (lo_ab >= c) ? c : lo_ab;
  assign a_new = (hi_ab >= hi_lc) ? hi_ab : hi_lc;
  assign b_new = (hi_ab >= hi_lc) ? hi_lc : hi_ab;

endmodule

`default_nettype wire

// File: rtl/cas3_sort_sched.sv
// cas3_sort_sched: buffers DEPTH words, sorts them descending with one shared cas3, drains them.
// Rev 1.0; define CAS3_SORT_SCHED_EARLY_EXIT_EN to stop after the first pass with no swaps.
`default_nettype none

module cas3_sort_sched
  import cas_pkg::*;
#(
  parameter int BITS  = CAS_BITS,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITS-1:0]        in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITS-1:0]        out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] pass_cnt
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = pass_cnt_width(DEPTH);

  state_t          state;
  logic [BITS-1:0] mem [DEPTH];
  logic [IW-1:0]   ld_idx;
  logic [IW-1:0]   w;
  logic [IW-1:0]   w1;
  logic [IW-1:0]   w2;
  logic [IW-1:0]   rd_idx;
  logic [BITS-1:0] a_new;
  logic [BITS-1:0] b_new;
  logic [BITS-1:0] c_new;
  logic            in_fire;
  logic            out_fire;
  logic            pass_end;
  logic            pass_done;

  assign w1       = w + IW'(1);
  assign w2       = w + IW'(2);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign pass_end = (w == IW'(DEPTH - 3));
  // The buffer is frozen during DRAIN, so a direct read keeps out_data stable under stall.
  assign out_data = mem[rd_idx];

  cas3 #(.BITS(BITS)) u_cas3 (
    .a     (mem[w]),
    .b     (mem[w1]),
    .c     (mem[w2]),
    .a_new (a_new),
    .b_new (b_new),
    .c_new (c_new)
  );

`ifdef CAS3_SORT_SCHED_EARLY_EXIT_EN
  logic dirty;
  logic changed;
  assign changed   = (a_new != mem[w]) || (b_new != mem[w1]) || (c_new != mem[w2]);
  assign pass_done = !(dirty || changed) || (pass_cnt == PW'(DEPTH - 2));
`else
  assign pass_done = (pass_cnt == PW'(DEPTH - 2));
`endif

  // Buffer contents are don't-care after reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (state == LOAD) begin
        if (in_fire && ld_idx == IW'(i)) mem[i] <= in_data;
      end else if (state == SORT) begin
        if (w == IW'(i))       mem[i] <= a_new;
        else if (w1 == IW'(i)) mem[i] <= b_new;
        else if (w2 == IW'(i)) mem[i] <= c_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      pass_cnt  <= '0;
      ld_idx    <= '0;
      w         <= '0;
      rd_idx    <= '0;
`ifdef CAS3_SORT_SCHED_EARLY_EXIT_EN
      dirty     <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (ld_idx == IW'(DEPTH - 1)) begin
              ld_idx   <= '0;
              state    <= SORT;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              w        <= '0;
              pass_cnt <= '0;
`ifdef CAS3_SORT_SCHED_EARLY_EXIT_EN
              dirty    <= 1'b0;
`endif
            end else begin
              ld_idx <= ld_idx + IW'(1);
            end
          end
        end
        SORT: begin
`ifdef CAS3_SORT_SCHED_EARLY_EXIT_EN
          dirty <= (pass_end && !pass_done) ? 1'b0 : (dirty || changed);
`endif
          if (pass_end) begin
            pass_cnt <= pass_cnt + PW'(1);
            w        <= '0;
            if (pass_done) begin
              state     <= DRAIN;
              busy      <= 1'b0;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
              rd_idx    <= '0;
            end
          end else begin
            w <= w + IW'(1);
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_last) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              pass_cnt  <= '0;
              rd_idx    <= '0;
            end else begin
              rd_idx   <= rd_idx + IW'(1);
              out_last <= (rd_idx == IW'(DEPTH - 2));
            end
          end
        end
        default: begin
          state     <= LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cas3_sort_sched.sv
// tb_cas3_sort_sched: directed and random blocks checked against a queue-based sort model.
// Rev 1.0
`default_nettype none

module tb_cas3_sort_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       busy;
  logic [3:0] pass_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [3:0] blk [8];
  int got_data [8];
  int got_last [8];
  int got;
  int busy_cnt;
  int pc_seen;

  always #10 clk = ~clk;

  cas3_sort_sched #(.BITS(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .pass_cnt  (pass_cnt)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Number of full 3-wide sweeps the scheduler should spend on the current block.
  function automatic int model_passes();
    int  m [8];
    int  t [$];
    int  p;
    bit  ch;
    bit  early;
`ifdef CAS3_SORT_SCHED_EARLY_EXIT_EN
    early = 1'b1;
`else
    early = 1'b0;
`endif
    p = 0;
    foreach (m[i]) m[i] = int'(blk[i]);
    do begin
      ch = 1'b0;
      for (int k = 0; k <= 5; k++) begin
        t = {m[k], m[k+1], m[k+2]};
        t.rsort();
        if (t[0] != m[k] || t[1] != m[k+1] || t[2] != m[k+2]) ch = 1'b1;
        m[k] = t[0]; m[k+1] = t[1]; m[k+2] = t[2];
      end
      p++;
    end while ((early ? ch : 1'b1) && p < 7);
    return p;
  endfunction

  task automatic load_block(input bit rnd);
    for (int i = 0; i < 8; i++) begin
      bit x = 1'b0;
      int g = 0;
      while (!x) begin
        @(negedge clk);
        in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = blk[i];
        x = in_valid && in_ready;
        g++;
        if (!x && g > 100) begin
          check("load_timeout", 0, 1);
          return;
        end
      end
    end
  endtask

  task automatic sort_wait(input bit rnd);
    int g = 0;
    busy_cnt = 0;
    @(negedge clk);
    while (!out_valid) begin
      if (busy) busy_cnt++;
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 4'($urandom_range(0, 15));
      g++;
      if (g > 200) begin
        check("sort_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic drain(input int mode, input int n);
    int         cyc = 0;
    bit         prev_stall = 1'b0;
    logic [3:0] pd = '0;
    logic       pl = 1'b0;
    got     = 0;
    pc_seen = int'(pass_cnt);
    while (got < n) begin
      if (prev_stall) begin
        check("stall_data", int'(out_data), int'(pd));
        check("stall_last", int'(out_last), int'(pl));
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      endcase
      in_valid = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        got_data[got] = int'(out_data);
        got_last[got] = int'(out_last);
        got++;
      end
      prev_stall = out_valid && !out_ready;
      pd  = out_data;
      pl  = out_last;
      cyc++;
      if (got < n && cyc > 200) begin
        check("drain_timeout", got, n);
        return;
      end
      if (got < n) @(negedge clk);
    end
  endtask

  task automatic run_block(input bit rnd, input int mode);
    int exp_q [$];
    int p;
    exp_q = {};
    foreach (blk[i]) exp_q.push_back(int'(blk[i]));
    exp_q.rsort();
    p = model_passes();
    load_block(rnd);
    sort_wait(rnd);
    drain(mode, 8);
    check("pass_cnt", pc_seen, p);
    check("busy_cycles", busy_cnt, p * 6);
    for (int i = 0; i < 8; i++) begin
      check("out_data", got_data[i], exp_q[i]);
      check("out_last", got_last[i], (i == 7) ? 1 : 0);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_out_last"}, int'(out_last), 0);
    check({tag, "_pass_cnt"}, int'(pass_cnt), 0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // Ascending input, full reversal.
    for (int i = 0; i < 8; i++) blk[i] = 4'(i);
    run_block(1'b0, 0);

    // Already descending.
    for (int i = 0; i < 8; i++) blk[i] = 4'(15 - i);
    run_block(1'b0, 0);

    // All keys equal.
    for (int i = 0; i < 8; i++) blk[i] = 4'd5;
    run_block(1'b0, 0);

    // Mixed keys with duplicates, consumer stalling in a 1,0,0,1 rhythm.
    blk = '{4'd3, 4'd9, 4'd1, 4'd12, 4'd0, 4'd7, 4'd7, 4'd2};
    run_block(1'b0, 2);

    // Abort in SORT.
    for (int i = 0; i < 8; i++) blk[i] = 4'($urandom_range(0, 15));
    load_block(1'b0);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_sort");
    rst = 1'b0;

    // Abort in DRAIN after a few words.
    load_block(1'b0);
    sort_wait(1'b0);
    drain(0, 3);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_idle("rst_drain");
    rst = 1'b0;

    for (int i = 0; i < 8; i++) blk[i] = 4'(i);
    run_block(1'b0, 0);

    // Random blocks with random handshakes on both sides.
    for (int b = 0; b < 400; b++) begin
      for (int i = 0; i < 8; i++) blk[i] = 4'($urandom_range(0, 15));
      run_block(1'b1, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
